fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction fetch stage. Holds the program counter and the IF/ID
//             pipeline register, and selects the next PC from redirect, stall,
//             optional static prediction and sequential PC+4.
//  Config   : define STATIC_BTFN_PREDICT_EN to compile in static
//             backward-taken / forward-not-taken prediction (JAL always taken,
//             conditional branches taken when the offset is negative).
//  Ports    :
//    clk_i          in   1   clock, rising edge
//    rst_n_i        in   1   asynchronous active-low reset
//    stall_i        in   1   hold PC and IF/ID
//    flush_i        in   1   bubble IF/ID
//    redirect_en_i  in   1   load PC from redirect_pc_i, bubble IF/ID
//    redirect_pc_i  in  32   redirect target (bits [1:0] ignored)
//    imem_addr_o    out 32   instruction memory address (= PC register)
//    imem_rdata_i   in  32   instruction word at imem_addr_o, same cycle
//    instr_o        out 32   IF/ID instruction
//    pc_o           out 32   IF/ID PC
//    pc_plus4_o     out 32   IF/ID PC+4
//    valid_o        out  1   IF/ID holds a real instruction
//    pred_taken_o   out  1   IF/ID instruction was predicted taken
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_en_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
    output logic        pred_taken_o
);

    localparam logic [31:0] c_pc_step = 32'd4;

    logic [31:0] r_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic [31:0] w_redirect_pc;
    logic        w_pred_taken;
    logic [31:0] w_pred_target;

    // Wraps naturally modulo 2^32.
    assign w_pc_plus4    = r_pc + c_pc_step;
    assign w_redirect_pc = {redirect_pc_i[31:2], 2'b00};

`ifdef STATIC_BTFN_PREDICT_EN
    logic [6:0]  w_opcode;
    logic        w_is_jal;
    logic        w_is_branch;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_b;

    assign w_opcode    = imem_rdata_i[6:0];
    assign w_is_jal    = (w_opcode == 7'b1101111);
    assign w_is_branch = (w_opcode == 7'b1100011);

    assign w_imm_j = {{12{imem_rdata_i[31]}}, imem_rdata_i[19:12],
                      imem_rdata_i[20], imem_rdata_i[30:21], 1'b0};
    assign w_imm_b = {{20{imem_rdata_i[31]}}, imem_rdata_i[7],
                      imem_rdata_i[30:25], imem_rdata_i[11:8], 1'b0};

    // Branch sign bit (instr[31]) set means a backward target: predict taken.
    // Prediction is dropped whenever the PC is held or overridden this cycle.
    assign w_pred_taken  = (w_is_jal | (w_is_branch & imem_rdata_i[31]))
                           & ~stall_i & ~redirect_en_i;
    assign w_pred_target = r_pc + (w_is_jal ? w_imm_j : w_imm_b);
`else
    assign w_pred_taken  = 1'b0;
    assign w_pred_target = w_pc_plus4;
`endif

    // Next PC priority: redirect > stall hold > prediction > sequential.
    always_comb begin
        w_pc_next = w_pc_plus4;
        if (redirect_en_i) begin
            w_pc_next = w_redirect_pc;
        end else if (stall_i) begin
            w_pc_next = r_pc;
        end else if (w_pred_taken) begin
            w_pc_next = w_pred_target;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign imem_addr_o = r_pc;

    // IF/ID register. A bubble keeps pc_o/pc_plus4_o so downstream PC-relative
    // logic never sees a spurious value on an invalid slot.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            instr_o      <= NOP_INSTR;
            pc_o         <= 32'h0000_0000;
            pc_plus4_o   <= 32'h0000_0000;
            valid_o      <= 1'b0;
            pred_taken_o <= 1'b0;
        end else if (redirect_en_i || flush_i) begin
            instr_o      <= NOP_INSTR;
            valid_o      <= 1'b0;
            pred_taken_o <= 1'b0;
        end else if (!stall_i) begin
            instr_o      <= imem_rdata_i;
            pc_o         <= r_pc;
            pc_plus4_o   <= w_pc_plus4;
            valid_o      <= 1'b1;
            pred_taken_o <= w_pred_taken;
        end
    end

endmodule
`default_nettype wire
